// File: rtl/gpg_spi_set_sched.sv
// gpg_spi_set_sched
//   Schedules GoPiGo3 SET commands onto a byte-level SPI master. There are N_CH
//   channels. Each channel holds a message-type byte and CH_BYTES data bytes.
//   The block detects when a channel's inputs change and marks that channel
//   dirty. It picks dirty, enabled channels round-robin. For each pick it sends
//   one frame of bytes: SPI_ADDR, type, then data MSB first. An optional
//   periodic refresh marks every enabled channel dirty again. A watchdog aborts
//   a byte that never completes.
//
// Ports
//   clk, rst_n       clock; asynchronous active-low reset (deassertion synchronised)
//   ch_data_i        channel k data at [k*CH_BYTES*8 +: CH_BYTES*8]
//   ch_type_i        channel k message type at [k*8 +: 8]
//   ch_en_i          per-channel enable; a disabled channel is never sent,
//                    but its dirty bit is kept
//   resend_i         pulse: mark all enabled channels dirty
//   ena_2clk_o       free-running enable pulse every ENA_DIV clocks (2*SCLK)
//   spi_start_o      one-cycle byte start; spi_tx_o holds the byte
//   spi_busy_i       SPI master busy
//   spi_irq_i        byte done, held by the master until acked
//   spi_ack_o        one-cycle acknowledge of spi_irq_i
//   spi_ss_n         slave select, active low, framing one transaction
//   busy_o           scheduler is inside a frame or its trailing gap
//   sent_vld_o       pulse: frame completed
//   sent_ch_o        channel of the last completed or aborted frame
//   err_o            pulse: frame aborted by timeout
//
// Byte handshake with the SPI master:
//   A byte is offered by pulsing spi_start_o for one cycle, and only while
//   spi_busy_i is low. spi_tx_o is valid in that cycle.
//   The master reports completion by raising spi_irq_i and holding it high.
//   The scheduler consumes the completion by pulsing spi_ack_o for one cycle.
//   No new start is issued until that ack has been given.
module gpg_spi_set_sched #(
    parameter int         N_CH           = 4,
    parameter int         CH_BYTES       = 2,
    parameter logic [7:0] SPI_ADDR       = 8'h08,
    parameter int         G_CLK_FREQ_MHZ = 50,
    parameter int         SPI_KHZ        = 500,
    parameter int         GAP_CYC        = 64,
    parameter int         REFRESH_CYC    = 0,
    parameter int         TIMEOUT_CYC    = 4096,
    localparam int        CH_W           = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_CH*CH_BYTES*8-1:0] ch_data_i,
    input  logic [N_CH*8-1:0]          ch_type_i,
    input  logic [N_CH-1:0]            ch_en_i,
    input  logic                       resend_i,
    output logic                       ena_2clk_o,
    output logic                       spi_start_o,
    output logic [7:0]                 spi_tx_o,
    input  logic                       spi_busy_i,
    input  logic                       spi_irq_i,
    output logic                       spi_ack_o,
    output logic                       spi_ss_n,
    output logic                       busy_o,
    output logic                       sent_vld_o,
    output logic [CH_W-1:0]            sent_ch_o,
    output logic                       err_o
);
    localparam int ENA_RAW = (G_CLK_FREQ_MHZ * 1000) / (2 * SPI_KHZ);
    localparam int ENA_DIV = (ENA_RAW < 2) ? 2 : ENA_RAW;
    localparam int DIV_W   = $clog2(ENA_DIV);
    localparam int REC_W   = 8 + CH_BYTES * 8;
    localparam int N_BYTES = CH_BYTES + 2;
    localparam int IDX_W   = $clog2(N_BYTES);
    localparam int TMO_W   = $clog2(TIMEOUT_CYC + 1);
    localparam int GAP_W   = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam int REF_W   = (REFRESH_CYC > 1) ? $clog2(REFRESH_CYC) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ARB   = 3'd1;
    localparam logic [2:0] S_SETUP = 3'd2;
    localparam logic [2:0] S_SEND  = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;
    localparam logic [2:0] S_HOLD  = 3'd5;
    localparam logic [2:0] S_GAP   = 3'd6;

    // The reset asserts asynchronously but releases two clocks later, in step
    // with clk. This keeps every flop leaving reset in the same cycle.
    logic [1:0] rst_sync_q, rst_sync_d;
    logic       rst_int_n;

    logic [2:0]       state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             ena_q, ena_d;
    logic [REF_W-1:0] ref_q, ref_d;
    logic [CH_W-1:0]  rr_q, rr_d, sel_q, sel_d, sent_ch_q, sent_ch_d;
    logic [REC_W-1:0] snap_q, snap_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [7:0]       tx_q, tx_d;
    logic             ss_n_q, ss_n_d, start_q, start_d, ack_q, ack_d;
    logic             sent_vld_q, sent_vld_d, err_q, err_d;
    logic [N_CH-1:0]  dirty_q, dirty_d;
    logic [REC_W-1:0] shadow_q [N_CH];
    logic [REC_W-1:0] shadow_d [N_CH];
    logic [REC_W-1:0] rec      [N_CH];

    logic [N_CH-1:0]  cand;
    logic             found, tick, complete;
    logic [CH_W-1:0]  pick;
    logic [7:0]       cur_byte;

    always_comb begin
        rst_sync_d = {rst_sync_q[0], 1'b1};
    end
    assign rst_int_n = rst_sync_q[1];

    always_comb begin
        for (int k = 0; k < N_CH; k++) begin
            rec[k] = {ch_type_i[k*8 +: 8], ch_data_i[k*CH_BYTES*8 +: CH_BYTES*8]};
        end
    end

    // Enable divider and refresh counter, both free-running.
    always_comb begin
        ena_d = (div_q == DIV_W'(ENA_DIV - 1));
        div_d = ena_d ? '0 : div_q + DIV_W'(1);
        tick  = 1'b0;
        ref_d = ref_q;
        if (REFRESH_CYC > 0) begin
            tick  = (ref_q == REF_W'(REFRESH_CYC - 1));
            ref_d = tick ? '0 : ref_q + REF_W'(1);
        end
    end

    // Round-robin search: the first dirty, enabled channel at or after rr_q.
    always_comb begin
        cand  = dirty_q & ch_en_i;
        found = 1'b0;
        pick  = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (!found && cand[(int'(rr_q) + i) % N_CH]) begin
                found = 1'b1;
                pick  = CH_W'((int'(rr_q) + i) % N_CH);
            end
        end
    end

    // Byte index 0 is the address. Indices 1.. walk the {type, data} snapshot
    // from its top byte down, so data goes out MSB first.
    always_comb begin
        cur_byte = SPI_ADDR;
        for (int i = 1; i < N_BYTES; i++) begin
            if (idx_q == IDX_W'(i)) cur_byte = snap_q[(N_BYTES - 1 - i) * 8 +: 8];
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        sel_d      = sel_q;
        snap_d     = snap_q;
        idx_d      = idx_q;
        gap_d      = gap_q;
        tx_d       = tx_q;
        ss_n_d     = ss_n_q;
        sent_ch_d  = sent_ch_q;
        start_d    = 1'b0;
        ack_d      = 1'b0;
        sent_vld_d = 1'b0;
        err_d      = 1'b0;
        complete   = 1'b0;
        tmo_d      = (tmo_q == TMO_W'(TIMEOUT_CYC)) ? tmo_q : tmo_q + TMO_W'(1);
        case (state_q)
            S_IDLE: if (|cand) state_d = S_ARB;
            S_ARB: begin
                if (found) begin
                    sel_d   = pick;
                    snap_d  = rec[pick];
                    rr_d    = (pick == CH_W'(N_CH - 1)) ? '0 : pick + CH_W'(1);
                    idx_d   = '0;
                    ss_n_d  = 1'b0;
                    state_d = S_SETUP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SETUP: if (ena_q) state_d = S_SEND;
            S_SEND: begin
                if (!spi_busy_i) begin
                    start_d = 1'b1;
                    tx_d    = cur_byte;
                    tmo_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (spi_irq_i) begin
                    ack_d = 1'b1;
                    if (idx_q == IDX_W'(N_BYTES - 1)) begin
                        state_d = S_HOLD;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = S_SEND;
                    end
                end else if (tmo_q >= TMO_W'(TIMEOUT_CYC - 1)) begin
                    // Abort: ack any late completion, release the slave, keep the channel dirty.
                    ack_d     = 1'b1;
                    ss_n_d    = 1'b1;
                    err_d     = 1'b1;
                    sent_ch_d = sel_q;
                    gap_d     = '0;
                    state_d   = S_GAP;
                end
            end
            S_HOLD: begin
                if (ena_q) begin
                    ss_n_d     = 1'b1;
                    complete   = 1'b1;
                    sent_vld_d = 1'b1;
                    sent_ch_d  = sel_q;
                    gap_d      = '0;
                    state_d    = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_W'(GAP_CYC - 1)) state_d = S_IDLE;
                else gap_d = gap_q + GAP_W'(1);
            end
            default: state_d = S_IDLE;
        endcase

        // On completion the channel that was just sent is compared against
        // its snapshot instead of its old shadow. That way a value which
        // changed again during the frame stays dirty. Any set condition
        // (including resend/refresh) overrides the clear.
        for (int k = 0; k < N_CH; k++) begin
            logic done_k;
            done_k      = complete && (sel_q == CH_W'(k));
            shadow_d[k] = done_k ? snap_q : shadow_q[k];
            dirty_d[k]  = (ch_en_i[k] && ((rec[k] != shadow_d[k]) || resend_i || tick))
                          || (dirty_q[k] && !done_k);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= '0;
        else        rst_sync_q <= rst_sync_d;
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q    <= S_IDLE;
            div_q      <= '0;
            ena_q      <= 1'b0;
            ref_q      <= '0;
            rr_q       <= '0;
            sel_q      <= '0;
            snap_q     <= '0;
            idx_q      <= '0;
            tmo_q      <= '0;
            gap_q      <= '0;
            tx_q       <= '0;
            ss_n_q     <= 1'b1;
            start_q    <= 1'b0;
            ack_q      <= 1'b0;
            sent_vld_q <= 1'b0;
            sent_ch_q  <= '0;
            err_q      <= 1'b0;
            dirty_q    <= '1;
            for (int k = 0; k < N_CH; k++) shadow_q[k] <= '0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            ena_q      <= ena_d;
            ref_q      <= ref_d;
            rr_q       <= rr_d;
            sel_q      <= sel_d;
            snap_q     <= snap_d;
            idx_q      <= idx_d;
            tmo_q      <= tmo_d;
            gap_q      <= gap_d;
            tx_q       <= tx_d;
            ss_n_q     <= ss_n_d;
            start_q    <= start_d;
            ack_q      <= ack_d;
            sent_vld_q <= sent_vld_d;
            sent_ch_q  <= sent_ch_d;
            err_q      <= err_d;
            dirty_q    <= dirty_d;
            for (int k = 0; k < N_CH; k++) shadow_q[k] <= shadow_d[k];
        end
    end

    assign ena_2clk_o  = ena_q;
    assign spi_start_o = start_q;
    assign spi_tx_o    = tx_q;
    assign spi_ack_o   = ack_q;
    assign spi_ss_n    = ss_n_q;
    assign busy_o      = (state_q != S_IDLE) && (state_q != S_ARB);
    assign sent_vld_o  = sent_vld_q;
    assign sent_ch_o   = sent_ch_q;
    assign err_o       = err_q;
endmodule

// File: tb/tb_gpg_spi_set_sched.sv
module tb_gpg_spi_set_sched;
    localparam int GAP = 16;
    localparam int TMO = 200;
    localparam int BOUND = 4000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic r_rst_n = 1'b0;
    always #5 clk = ~clk;

    // Main DUT (no refresh)
    logic [63:0] ch_data;
    logic [31:0] ch_type;
    logic [3:0]  ch_en;
    logic        resend;
    logic        ena_2clk, spi_start, spi_busy, spi_irq, spi_ack, spi_ss_n;
    logic        busy, sent_vld, err;
    logic [7:0]  spi_tx;
    logic [1:0]  sent_ch;
    logic        no_irq;

    gpg_spi_set_sched #(.N_CH(4), .CH_BYTES(2), .SPI_ADDR(8'h08), .G_CLK_FREQ_MHZ(50),
        .SPI_KHZ(12500), .GAP_CYC(GAP), .REFRESH_CYC(0), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .ch_data_i(ch_data), .ch_type_i(ch_type), .ch_en_i(ch_en),
        .resend_i(resend), .ena_2clk_o(ena_2clk), .spi_start_o(spi_start), .spi_tx_o(spi_tx),
        .spi_busy_i(spi_busy), .spi_irq_i(spi_irq), .spi_ack_o(spi_ack), .spi_ss_n(spi_ss_n),
        .busy_o(busy), .sent_vld_o(sent_vld), .sent_ch_o(sent_ch), .err_o(err));

    // Refresh DUT, static inputs, channel 2 disabled
    logic [63:0] r_data = 64'h0004_0003_0002_0001;
    logic [31:0] r_type = 32'h2322_2120;
    logic [3:0]  r_en = 4'b1011;
    logic        r_resend = 1'b0;
    logic        r_ena, r_start, r_busy, r_irq, r_ack, r_ss_n, r_bsy, r_vld, r_err;
    logic [7:0]  r_tx;
    logic [1:0]  r_ch;

    gpg_spi_set_sched #(.N_CH(4), .CH_BYTES(2), .SPI_ADDR(8'h08), .G_CLK_FREQ_MHZ(50),
        .SPI_KHZ(12500), .GAP_CYC(GAP), .REFRESH_CYC(10000), .TIMEOUT_CYC(TMO)) dut_r (
        .clk(clk), .rst_n(r_rst_n), .ch_data_i(r_data), .ch_type_i(r_type), .ch_en_i(r_en),
        .resend_i(r_resend), .ena_2clk_o(r_ena), .spi_start_o(r_start), .spi_tx_o(r_tx),
        .spi_busy_i(r_busy), .spi_irq_i(r_irq), .spi_ack_o(r_ack), .spi_ss_n(r_ss_n),
        .busy_o(r_bsy), .sent_vld_o(r_vld), .sent_ch_o(r_ch), .err_o(r_err));

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    logic [1:0] sent_q[$];
    logic [1:0] exp_ch[$];
    int r_cnt [4] = '{0, 0, 0, 0};

    // Byte-level SPI master model for the main DUT
    int m_cnt = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            spi_busy = 1'b0; spi_irq = 1'b0; m_cnt = 0;
        end else begin
            cyc++;
            if (spi_ack) spi_irq = 1'b0;
            if (spi_start) begin
                got_q.push_back(spi_tx); spi_busy = 1'b1; m_cnt = 3;
            end else if (spi_busy) begin
                if (m_cnt == 0) begin spi_busy = 1'b0; if (!no_irq) spi_irq = 1'b1; end
                else m_cnt--;
            end
            if (sent_vld) sent_q.push_back(sent_ch);
        end
    end

    // Master model for the refresh DUT
    int r_mcnt = 0;
    always @(negedge clk) begin
        if (!r_rst_n) begin
            r_busy = 1'b0; r_irq = 1'b0; r_mcnt = 0;
        end else begin
            if (r_ack) r_irq = 1'b0;
            if (r_start) begin r_busy = 1'b1; r_mcnt = 3; end
            else if (r_busy) begin
                if (r_mcnt == 0) begin r_busy = 1'b0; r_irq = 1'b1; end
                else r_mcnt--;
            end
            if (r_vld) r_cnt[r_ch]++;
        end
    end

    task automatic set_ch(input int k, input logic [7:0] t, input logic [15:0] d);
        ch_type[k*8 +: 8] = t;
        ch_data[k*16 +: 16] = d;
    endtask

    task automatic push_frame(input logic [1:0] ch, input logic [7:0] t, input logic [15:0] d);
        exp_q.push_back(8'h08); exp_q.push_back(t); exp_q.push_back(d[15:8]); exp_q.push_back(d[7:0]);
        exp_ch.push_back(ch);
    endtask

    task automatic clear_logs();
        got_q.delete(); sent_q.delete(); exp_q.delete(); exp_ch.delete();
    endtask

    task automatic wait_sent(input int n, output bit ok);
        int t;
        t = 0;
        while (sent_q.size() < n && t < BOUND) begin @(negedge clk); t++; end
        while (busy && t < BOUND) begin @(negedge clk); t++; end
        repeat (4) @(negedge clk);
        ok = (t < BOUND);
    endtask

    task automatic wait_start(output bit ok);
        int t;
        t = 0;
        while (!spi_start && t < BOUND) begin @(negedge clk); t++; end
        ok = (t < BOUND);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({spi_ss_n, spi_start, spi_tx, sent_ch, busy, sent_vld, err, spi_ack} !== {1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs got ss_n=%b start=%b tx=%02h ch=%0d busy=%b vld=%b err=%b ack=%b req 1 0 00 0 0 0 0 0",
                     spi_ss_n, spi_start, spi_tx, sent_ch, busy, sent_vld, err, spi_ack);
        end
        rst_n = 1'b1;
        r_rst_n = 1'b1;
    endtask

    task automatic test_ena();
        int t;
        int gap;
        t = 0;
        while (!ena_2clk && t < 20) begin @(negedge clk); t++; end
        gap = 0;
        do begin @(negedge clk); gap++; end while (!ena_2clk && gap < 20);
        checks++;
        if (gap !== 2) begin errors++; $display("FAIL ena_period got %0d required 2", gap); end
    endtask

    task automatic test_initial();
        bit ok;
        wait_start(ok);
        checks++;
        if (!ok || spi_ss_n !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL init_framing ok=%b ss_n=%b busy=%b required 1 0 1", ok, spi_ss_n, busy);
        end
        push_frame(0, 8'h10, 16'h0064); push_frame(1, 8'h11, 16'h00C8);
        push_frame(2, 8'h12, 16'h012C); push_frame(3, 8'h13, 16'h0190);
        wait_sent(4, ok);
        checks++;
        if (!ok || got_q.size() != exp_q.size()) begin errors++; $display("FAIL init_len got %0d required %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL init_byte%0d got %02h required %02h", i, got_q[i], exp_q[i]); end
        end
        checks++;
        if (sent_q.size() != exp_ch.size()) begin errors++; $display("FAIL init_nsent got %0d required %0d", sent_q.size(), exp_ch.size()); end
        foreach (exp_ch[i]) if (i < sent_q.size()) begin
            checks++; if (sent_q[i] !== exp_ch[i]) begin errors++; $display("FAIL init_ch%0d got %0d required %0d", i, sent_q[i], exp_ch[i]); end
        end
        checks++;
        if (spi_ss_n !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL init_idle ss_n=%b busy=%b required 1 0", spi_ss_n, busy); end
    endtask

    task automatic test_ch2_change();
        bit ok;
        clear_logs();
        set_ch(2, 8'h12, 16'h0258);
        push_frame(2, 8'h12, 16'h0258);
        wait_sent(1, ok);
        checks++;
        if (!ok || got_q.size() != exp_q.size()) begin errors++; $display("FAIL ch2_len got %0d required %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL ch2_byte%0d got %02h required %02h", i, got_q[i], exp_q[i]); end
        end
        checks++;
        if (sent_q.size() != 1 || sent_ch !== 2'd2) begin errors++; $display("FAIL ch2_sent_ch got n=%0d ch=%0d required n=1 ch=2", sent_q.size(), sent_ch); end
    endtask

    task automatic test_round_robin();
        bit ok;
        clear_logs();
        set_ch(1, 8'h11, 16'h1234);
        push_frame(1, 8'h11, 16'h1234);
        wait_sent(1, ok);
        set_ch(1, 8'h11, 16'h5678);
        set_ch(3, 8'h13, 16'h9ABC);
        push_frame(3, 8'h13, 16'h9ABC); push_frame(1, 8'h11, 16'h5678);
        wait_sent(3, ok);
        checks++;
        if (!ok || got_q.size() != exp_q.size()) begin errors++; $display("FAIL rr_len got %0d required %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rr_byte%0d got %02h required %02h", i, got_q[i], exp_q[i]); end
        end
        checks++;
        if (sent_q.size() != exp_ch.size()) begin errors++; $display("FAIL rr_nsent got %0d required %0d", sent_q.size(), exp_ch.size()); end
        foreach (exp_ch[i]) if (i < sent_q.size()) begin
            checks++; if (sent_q[i] !== exp_ch[i]) begin errors++; $display("FAIL rr_ch%0d got %0d required %0d", i, sent_q[i], exp_ch[i]); end
        end
    endtask

    task automatic test_midframe_change();
        bit ok;
        clear_logs();
        set_ch(0, 8'h10, 16'h0A0B);
        wait_start(ok);
        set_ch(0, 8'h10, 16'h0C0D);
        push_frame(0, 8'h10, 16'h0A0B); push_frame(0, 8'h10, 16'h0C0D);
        wait_sent(2, ok);
        checks++;
        if (!ok || got_q.size() != exp_q.size()) begin errors++; $display("FAIL mid_len got %0d required %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL mid_byte%0d got %02h required %02h", i, got_q[i], exp_q[i]); end
        end
        checks++;
        if (sent_q.size() != 2) begin errors++; $display("FAIL mid_nsent got %0d required 2", sent_q.size()); end
    endtask

    task automatic test_timeout();
        bit ok;
        int cnt;
        clear_logs();
        no_irq = 1'b1;
        set_ch(3, 8'h13, 16'h4321);
        wait_start(ok);
        cnt = 0;
        do begin @(negedge clk); cnt++; end while (!err && cnt < BOUND);
        checks++;
        if (!ok || cnt !== TMO) begin errors++; $display("FAIL tmo_latency got %0d required %0d", cnt, TMO); end
        checks++;
        if (spi_ss_n !== 1'b1 || sent_ch !== 2'd3 || sent_q.size() != 0) begin
            errors++; $display("FAIL tmo_abort ss_n=%b ch=%0d nsent=%0d required 1 3 0", spi_ss_n, sent_ch, sent_q.size());
        end
        @(negedge clk);
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL tmo_err_pulse got %b required 0", err); end
        no_irq = 1'b0;
        got_q.delete();
        push_frame(3, 8'h13, 16'h4321);
        wait_sent(1, ok);
        checks++;
        if (!ok || got_q.size() != exp_q.size()) begin errors++; $display("FAIL tmo_retry_len got %0d required %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL tmo_retry_byte%0d got %02h required %02h", i, got_q[i], exp_q[i]); end
        end
        checks++;
        if (sent_q.size() != 1 || sent_ch !== 2'd3) begin errors++; $display("FAIL tmo_retry_ch n=%0d ch=%0d required 1 3", sent_q.size(), sent_ch); end
    endtask

    task automatic test_resend_enable();
        bit ok;
        clear_logs();
        ch_en = 4'b1101;
        set_ch(1, 8'h11, 16'h0BAD);
        resend = 1'b1;
        @(negedge clk);
        resend = 1'b0;
        push_frame(0, 8'h10, 16'h0C0D); push_frame(2, 8'h12, 16'h0258); push_frame(3, 8'h13, 16'h4321);
        wait_sent(3, ok);
        ch_en = 4'b1111;
        push_frame(1, 8'h11, 16'h0BAD);
        wait_sent(4, ok);
        checks++;
        if (!ok || got_q.size() != exp_q.size()) begin errors++; $display("FAIL resend_len got %0d required %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL resend_byte%0d got %02h required %02h", i, got_q[i], exp_q[i]); end
        end
        checks++;
        if (sent_q.size() != exp_ch.size()) begin errors++; $display("FAIL resend_nsent got %0d required %0d", sent_q.size(), exp_ch.size()); end
        foreach (exp_ch[i]) if (i < sent_q.size()) begin
            checks++; if (sent_q[i] !== exp_ch[i]) begin errors++; $display("FAIL resend_ch%0d got %0d required %0d", i, sent_q[i], exp_ch[i]); end
        end
    endtask

    task automatic test_refresh();
        int mark [3] = '{9000, 15000, 25000};
        for (int m = 0; m < 3; m++) begin
            while (cyc < mark[m]) @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (r_cnt[k] !== ((k == 2) ? 0 : m + 1)) begin
                    errors++; $display("FAIL refresh_cnt cyc=%0d ch%0d got %0d required %0d", mark[m], k, r_cnt[k], (k == 2) ? 0 : m + 1);
                end
            end
        end
    endtask

    task automatic test_reset_midframe();
        bit ok;
        resend = 1'b1;
        @(negedge clk);
        resend = 1'b0;
        wait_start(ok);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (!ok || spi_ss_n !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_midframe ok=%b ss_n=%b busy=%b required 1 1 0", ok, spi_ss_n, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        no_irq = 1'b0;
        resend = 1'b0;
        ch_en = 4'b1111;
        ch_data = '0;
        ch_type = '0;
        set_ch(0, 8'h10, 16'h0064);
        set_ch(1, 8'h11, 16'h00C8);
        set_ch(2, 8'h12, 16'h012C);
        set_ch(3, 8'h13, 16'h0190);
        test_reset();
        test_ena();
        test_initial();
        test_ch2_change();
        test_round_robin();
        test_midframe_change();
        test_timeout();
        test_resend_enable();
        test_refresh();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
